// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one registered SLL/SRL/SRA/pass shifter between requesters A and B; SHIFT_ARB_STATS_EN adds grant counters.
// Latency: 1 cycle from accept to rsp_valid; one result per cycle when rsp_ready stays high.
// Backpressure: a held result with rsp_ready low blocks both a_ready and b_ready.
module shift_unit_arbiter #(
  parameter int N = 32,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [N-1:0]  a_in,
  input  logic [SW-1:0] a_shamt,
  input  logic [1:0]    a_op,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [N-1:0]  b_in,
  input  logic [SW-1:0] b_shamt,
  input  logic [1:0]    b_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
`ifdef SHIFT_ARB_STATS_EN
  output logic          rsp_id,
  output logic [15:0]   grant_cnt_a,
  output logic [15:0]   grant_cnt_b
`else
  output logic          rsp_id
`endif
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_nxt;
  logic   prio;
  logic   can_accept;
  logic   grant_b;
  logic   xfer;

  function automatic logic [N-1:0] do_shift(input logic [N-1:0] d,
                                            input logic [SW-1:0] sh,
                                            input logic [1:0] op);
    logic signed [N-1:0] sd;
    sd = d;
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return sd >>> sh;
      default: return d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Readiness is gated by rst_n so both readys read low throughout reset.
  always_comb begin
    state_nxt  = state;
    can_accept = rst_n && ((state == IDLE) || rsp_ready);
    grant_b    = b_valid && (!a_valid || prio);
    a_ready    = can_accept && a_valid && !grant_b;
    b_ready    = can_accept && grant_b;
    xfer       = a_ready || b_ready;
    rsp_valid  = (state == RESP);
    case (state)
      IDLE: if (xfer) state_nxt = RESP;
      RESP: begin
        if (xfer)           state_nxt = RESP;
        else if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      prio     <= 1'b0;
    end else if (xfer) begin
      rsp_data <= b_ready ? do_shift(b_in, b_shamt, b_op)
                          : do_shift(a_in, a_shamt, a_op);
      rsp_id   <= b_ready;
      prio     <= !b_ready;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else begin
      if (a_ready && grant_cnt_a != 16'hFFFF) grant_cnt_a <= grant_cnt_a + 16'd1;
      if (b_ready && grant_cnt_b != 16'hFFFF) grant_cnt_b <= grant_cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter: reset, shifts, contention, backpressure, boundaries, async reset.
module tb_shift_unit_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, a_ready;
  logic [31:0] a_in;
  logic [4:0]  a_shamt;
  logic [1:0]  a_op;
  logic        b_valid, b_ready;
  logic [31:0] b_in;
  logic [4:0]  b_shamt;
  logic [1:0]  b_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant_cnt_a, grant_cnt_b;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  shift_unit_arbiter #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in), .a_shamt(a_shamt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_in(b_in), .b_shamt(b_shamt), .b_op(b_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef SHIFT_ARB_STATS_EN
    .rsp_id(rsp_id), .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
`else
    .rsp_id(rsp_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    a_valid = 1'b1; a_in = '0; a_shamt = '0; a_op = 2'b00;
    b_valid = 1'b0; b_in = '0; b_shamt = '0; b_op = 2'b00;

    // Reset state, readys gated even with a request pending
    #3;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    a_valid = 1'b0;

    // A only: 1 << 4
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b1; a_in = 32'h0000_0001; a_shamt = 5'd4; a_op = 2'b00;
    #1;
    chk("a_only_ready", {31'd0, a_ready}, 32'd1);
    chk("a_only_b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b1; b_in = 32'h8000_0000; b_shamt = 5'd31; b_op = 2'b10;
    @(negedge clk);
    chk("a_only_valid", {31'd0, rsp_valid}, 32'd1);
    chk("a_only_data", rsp_data, 32'h0000_0010);
    chk("a_only_id", {31'd0, rsp_id}, 32'd0);
    chk("b_only_ready", {31'd0, b_ready}, 32'd1);

    // SRA then SRL on B
    @(posedge clk); #1;
    b_op = 2'b01;
    @(negedge clk);
    chk("sra_data", rsp_data, 32'hFFFF_FFFF);
    chk("sra_id", {31'd0, rsp_id}, 32'd1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("srl_data", rsp_data, 32'h0000_0001);
    chk("srl_id", {31'd0, rsp_id}, 32'd1);
    @(negedge clk);
    chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_data_hold", rsp_data, 32'h0000_0001);

    // Contention: alternate A, B, A, B
    a_valid = 1'b1; a_in = 32'h0000_0001; a_shamt = 5'd0; a_op = 2'b11;
    b_valid = 1'b1; b_in = 32'h0000_0002; b_shamt = 5'd0; b_op = 2'b11;
    #1;
    chk("cont_a_first", {31'd0, a_ready}, 32'd1);
    chk("cont_b_wait", {31'd0, b_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin a_valid = 1'b0; b_valid = 1'b0; end
      @(negedge clk);
      chk($sformatf("cont_id_%0d", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("cont_data_%0d", i), rsp_data, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("cont_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
    end

    // Backpressure for 5 cycles
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_in = 32'h0000_00F0; a_shamt = 5'd4; a_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_data_%0d", i), rsp_data, 32'h0000_0002);
      chk($sformatf("bp_id_%0d", i), {31'd0, rsp_id}, 32'd1);
      chk($sformatf("bp_a_ready_%0d", i), {31'd0, a_ready}, 32'd0);
      chk($sformatf("bp_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk); #1;
    a_in = 32'hDEAD_BEEF; a_shamt = 5'd0;
    @(negedge clk);
    chk("bp_release_data", rsp_data, 32'h0000_000F);
    chk("bp_release_id", {31'd0, rsp_id}, 32'd0);

    // shamt = 0 on every op
    for (int k = 0; k < 4; k++) begin
      a_op = 2'(k);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("sh0_op%0d", k), rsp_data, 32'hDEAD_BEEF);
    end
    a_shamt = 5'd4; a_op = 2'b00;
    @(posedge clk); #1; @(negedge clk);
    chk("sll4_data", rsp_data, 32'hEADB_EEF0);
    a_shamt = 5'd17; a_op = 2'b11;
    @(posedge clk); #1; @(negedge clk);
    chk("pass17_data", rsp_data, 32'hDEAD_BEEF);
    a_shamt = 5'd4; a_op = 2'b10;
    @(posedge clk); #1; @(negedge clk);
    chk("sra4_data", rsp_data, 32'hFDEA_DBEE);
    a_op = 2'b01;
    @(posedge clk); #1; @(negedge clk);
    chk("srl4_data", rsp_data, 32'h0DEA_DBEE);
    chk("srl4_valid", {31'd0, rsp_valid}, 32'd1);

    // Async reset while a result is held, away from any clock edge
    #2;
    rst_n = 1'b0; a_valid = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_data", rsp_data, 32'd0);
    a_valid = 1'b1; a_in = 32'h0000_0003; a_shamt = 5'd0; a_op = 2'b11;
    b_valid = 1'b1; b_in = 32'h0000_0004; b_shamt = 5'd0; b_op = 2'b11;
    #1;
    chk("arst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("arst_b_ready", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
    chk("post_rst_b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("post_rst_id0", {31'd0, rsp_id}, 32'd0);
    chk("post_rst_data0", rsp_data, 32'h0000_0003);
    chk("post_rst_b_next", {31'd0, b_ready}, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_id1", {31'd0, rsp_id}, 32'd1);
    chk("post_rst_data1", rsp_data, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
